// File: rtl/round_key_store.sv
// round_key_store: multi-context AES round-key memory.
// The key expansion engine fills contexts. The cipher streams a completed context
// forward (encrypt) or in reverse (decrypt). A one-entry prefetch register keeps
// the stream at full rate.
module round_key_store #(
  parameter  int KEY_W    = 128,
  parameter  int MAX_KEYS = 15,
  parameter  int NUM_CTX  = 2,
  localparam int IDX_W    = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1,
  localparam int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CTX_W-1:0]   wr_ctx,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               wr_last,
  input  logic [KEY_W-1:0]   wr_key,
  output logic               wr_err,
  output logic [NUM_CTX-1:0] ctx_valid,
  input  logic               rd_start,
  input  logic [CTX_W-1:0]   rd_ctx,
  input  logic               rd_rev,
  output logic               rd_ready,
  output logic               rd_err,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_last
);

  localparam int CNT_W = $clog2(MAX_KEYS + 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

  rd_state_t            state;
  logic [KEY_W-1:0]     mem [NUM_CTX][MAX_KEYS];
  logic [CNT_W-1:0]     num_keys [NUM_CTX];

  logic [CTX_W-1:0]     cur_ctx;
  logic                 cur_rev;
  logic [IDX_W-1:0]     cur_idx;
  logic [IDX_W-1:0]     end_idx;
  logic [KEY_W-1:0]     skid_key;
  logic                 skid_last;

  logic [2**CTX_W-1:0]  ctx_ok;
  logic [2**IDX_W-1:0]  idx_ok;
  logic [2**CTX_W-1:0]  valid_ext;
  logic                 wr_hit_stream;
  logic                 wr_ok;
  logic                 rd_accept;
  logic                 rd_go;
  logic [IDX_W-1:0]     rd_last_idx;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     fin_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 next_last;

  // Lookup masks for which context and index codes actually exist.
  for (genvar g = 0; g < 2**CTX_W; g++) begin : g_ctx_ok
    assign ctx_ok[g] = (g < NUM_CTX);
  end
  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_idx_ok
    assign idx_ok[g] = (g < MAX_KEYS);
  end

  // Widen the valid flags so any context code can be looked up safely.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_CTX-1:0] = ctx_valid;
  end

  assign rd_ready      = (state == IDLE);
  assign wr_hit_stream = (state != IDLE) && (wr_ctx == cur_ctx);
  assign wr_ok         = wr_en && ctx_ok[wr_ctx] && idx_ok[wr_idx] && !wr_hit_stream;
  assign rd_accept     = rd_start && rd_ready;
  assign rd_go         = rd_accept && ctx_ok[rd_ctx] && valid_ext[rd_ctx];

  assign rd_last_idx   = IDX_W'(num_keys[rd_ctx] - CNT_W'(1));
  assign start_idx     = rd_rev ? '0 : '0;
  assign fin_idx       = rd_rev ? '0 : rd_last_idx;
  assign next_idx      = cur_rev ? (cur_idx - IDX_W'(1)) : (cur_idx + IDX_W'(1));
  assign next_last     = (next_idx == end_idx);

  // Key storage is deliberately left unreset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ctx][wr_idx] <= wr_key;
    end
  end

  // Per-context completion bookkeeping and the write-reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_valid <= '0;
      wr_err    <= 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
        num_keys[i] <= '0;
      end
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_ok) begin
        if (wr_last) begin
          num_keys[wr_ctx]  <= CNT_W'(wr_idx) + CNT_W'(1);
          ctx_valid[wr_ctx] <= 1'b1;
        end else begin
          ctx_valid[wr_ctx] <= 1'b0;
        end
      end
    end
  end

  // Read FSM: issue the first read on accept, load the output in PRIME, then stream from the prefetch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ctx   <= '0;
      cur_rev   <= 1'b0;
      cur_idx   <= '0;
      end_idx   <= '0;
      skid_key  <= '0;
      skid_last <= 1'b0;
      key_out   <= '0;
      key_last  <= 1'b0;
      key_valid <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rd_err <= rd_accept && !rd_go;
      case (state)
        IDLE: begin
          if (rd_go) begin
            cur_ctx   <= rd_ctx;
            cur_rev   <= rd_rev;
            cur_idx   <= rd_rev ? rd_last_idx : start_idx;
            end_idx   <= fin_idx;
            skid_key  <= mem[rd_ctx][rd_rev ? rd_last_idx : start_idx];
            skid_last <= ((rd_rev ? rd_last_idx : start_idx) == fin_idx);
            state     <= PRIME;
          end
        end
        PRIME: begin
          key_out   <= skid_key;
          key_last  <= skid_last;
          key_valid <= 1'b1;
          if (!skid_last) begin
            cur_idx   <= next_idx;
            skid_key  <= mem[cur_ctx][next_idx];
            skid_last <= next_last;
          end
          state <= STREAM;
        end
        STREAM: begin
          if (key_valid && key_ready) begin
            if (key_last) begin
              key_valid <= 1'b0;
              key_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              key_out  <= skid_key;
              key_last <= skid_last;
              if (!skid_last) begin
                cur_idx   <= next_idx;
                skid_key  <= mem[cur_ctx][next_idx];
                skid_last <= next_last;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
